// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: start detection, bit timing, deserialization,
// parity/stop checking and a one-cycle strobe per received byte or error.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line idle, waiting for RX_IN low; sampler disabled
// START  | timing the start bit; a high vote means a glitch, not a frame
// DATA   | shifting DATA_WIDTH data bits in, LSB first
// PARITY | checking the parity bit against the received data
// STOP   | checking the stop bit; publishes the word if the frame is clean
module uart_rx_fsm #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  RX_IN,
   input  logic [4:0]            Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  sampled_bit,
   output logic                  data_samp_en,
   output logic [4:0]            edge_cnt,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  strt_glitch
);

   localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state, state_nxt;
   logic [4:0]            edge_nxt;
   logic [BCW-1:0]        bit_cnt, bit_nxt;
   logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
   logic [DATA_WIDTH-1:0] p_data_nxt;
   logic                  par_en_q, par_en_nxt;
   logic                  par_typ_q, par_typ_nxt;
   logic                  err_q, err_nxt;
   logic                  samp_en_nxt;
   logic                  dv_nxt, pe_nxt, se_nxt, sg_nxt;
   logic                  last_edge;
   logic                  exp_par;

   // Only the final oversampling edge of a bit consumes the sampler vote.
   assign last_edge = (edge_cnt == (Prescale - 5'd1));
   assign exp_par   = (^shift_reg) ^ par_typ_q;

   // State, counters, datapath and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         edge_cnt     <= 5'd0;
         bit_cnt      <= '0;
         shift_reg    <= '0;
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         err_q        <= 1'b0;
         P_DATA       <= '0;
         data_samp_en <= 1'b0;
         data_valid   <= 1'b0;
         par_err      <= 1'b0;
         stp_err      <= 1'b0;
         strt_glitch  <= 1'b0;
      end else begin
         state        <= state_nxt;
         edge_cnt     <= edge_nxt;
         bit_cnt      <= bit_nxt;
         shift_reg    <= shift_nxt;
         par_en_q     <= par_en_nxt;
         par_typ_q    <= par_typ_nxt;
         err_q        <= err_nxt;
         P_DATA       <= p_data_nxt;
         data_samp_en <= samp_en_nxt;
         data_valid   <= dv_nxt;
         par_err      <= pe_nxt;
         stp_err      <= se_nxt;
         strt_glitch  <= sg_nxt;
      end
   end

   // Next-state, bit timing and frame-check decisions.
   always_comb begin
      state_nxt   = state;
      edge_nxt    = 5'd0;
      bit_nxt     = bit_cnt;
      shift_nxt   = shift_reg;
      par_en_nxt  = par_en_q;
      par_typ_nxt = par_typ_q;
      err_nxt     = err_q;
      p_data_nxt  = P_DATA;
      dv_nxt      = 1'b0;
      pe_nxt      = 1'b0;
      se_nxt      = 1'b0;
      sg_nxt      = 1'b0;

      if ((state != IDLE) && !last_edge) begin
         edge_nxt = edge_cnt + 5'd1;
      end

      unique case (state)
         IDLE: begin
            if (!RX_IN) begin
               state_nxt   = START;
               par_en_nxt  = PAR_EN;
               par_typ_nxt = PAR_TYP;
               err_nxt     = 1'b0;
               bit_nxt     = '0;
            end
         end
         START: begin
            if (last_edge) begin
               if (sampled_bit) begin
                  sg_nxt    = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  bit_nxt   = '0;
                  state_nxt = DATA;
               end
            end
         end
         DATA: begin
            if (last_edge) begin
               shift_nxt = {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
               if (bit_cnt == LAST_BIT) begin
                  bit_nxt   = '0;
                  state_nxt = par_en_q ? PARITY : STOP;
               end else begin
                  bit_nxt = bit_cnt + 1'b1;
               end
            end
         end
         PARITY: begin
            if (last_edge) begin
               if (sampled_bit != exp_par) begin
                  pe_nxt  = 1'b1;
                  err_nxt = 1'b1;
               end
               state_nxt = STOP;
            end
         end
         STOP: begin
            if (last_edge) begin
               if (!sampled_bit) begin
                  se_nxt = 1'b1;
               end else if (!err_q) begin
                  p_data_nxt = shift_reg;
                  dv_nxt     = 1'b1;
               end
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      samp_en_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed and randomized bench for uart_rx_fsm. The reference is a frame-level
// model: strobe kinds and cycles follow from frame length, prescale and the
// parity rule applied to the byte value.
module tb_uart_rx_fsm;

   logic       clk;
   logic       reset;
   logic       RX_IN;
   logic [4:0] Prescale;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       sampled_bit;
   logic       data_samp_en;
   logic [4:0] edge_cnt;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;
   logic       strt_glitch;

   uart_rx_fsm #(.DATA_WIDTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .RX_IN        (RX_IN),
      .Prescale     (Prescale),
      .PAR_EN       (PAR_EN),
      .PAR_TYP      (PAR_TYP),
      .sampled_bit  (sampled_bit),
      .data_samp_en (data_samp_en),
      .edge_cnt     (edge_cnt),
      .P_DATA       (P_DATA),
      .data_valid   (data_valid),
      .par_err      (par_err),
      .stp_err      (stp_err),
      .strt_glitch  (strt_glitch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_err    = 0;
   int         cyc      = 0;
   int         cur_p    = 8;
   int         last_dv  = 0;
   logic [7:0] pdata_model = 8'h00;

   int         dv_q[$];
   logic [7:0] dvd_q[$];
   int         pe_q[$];
   int         se_q[$];
   int         sg_q[$];

   initial begin
      #5000000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // Advance one cycle and log every strobe with its cycle number.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (data_valid) begin
         dv_q.push_back(cyc);
         dvd_q.push_back(P_DATA);
      end
      if (par_err)     pe_q.push_back(cyc);
      if (stp_err)     se_q.push_back(cyc);
      if (strt_glitch) sg_q.push_back(cyc);
   endtask

   // Drives a frame starting in the current cycle (the IDLE detect cycle).
   task automatic drive_frame(input logic [7:0] d, input bit pen, input bit pbit, input bit stp,
                              input int abort_off, output int s);
      logic [31:0] bits;
      int          nb;
      int          edge_bad;
      int          en_bad;
      bit          aborted;
      nb       = pen ? 11 : 10;
      bits     = '0;
      for (int i = 0; i < 8; i++) bits[1+i] = d[i];
      if (pen) bits[9] = pbit;
      bits[nb-1] = stp;
      edge_bad = 0;
      en_bad   = 0;
      aborted  = 1'b0;
      RX_IN    = 1'b0;
      s        = cyc + 1;
      for (int k = 0; k < nb && !aborted; k++) begin
         for (int j = 0; j < cur_p && !aborted; j++) begin
            tick();
            if (abort_off >= 0 && cyc == s + abort_off) begin
               aborted = 1'b1;
            end else begin
               RX_IN       = bits[k];
               sampled_bit = bits[k];
               if (k == 0 && j == 0) begin
                  PAR_EN  = 1'($urandom);
                  PAR_TYP = 1'($urandom);
               end
               if (edge_cnt !== 5'(j))     edge_bad++;
               if (data_samp_en !== 1'b1) en_bad++;
            end
         end
      end
      chk("edge_cnt_seq", 32'(edge_bad), 32'd0);
      chk("samp_en_high", 32'(en_bad), 32'd0);
   endtask

   // Cycle S + N*Prescale: strobes land here and the sampler is off again.
   task automatic end_frame();
      tick();
      RX_IN       = 1'b1;
      sampled_bit = 1'b1;
      chk("samp_en_fall", 32'(data_samp_en), 32'd0);
      chk("edge_cnt_idle", 32'(edge_cnt), 32'd0);
   endtask

   task automatic expect_frame(input int s, input logic [7:0] d, input bit pen, input bit ptyp,
                               input bit pbit, input bit stp);
      int nb;
      int t_end;
      int t_par;
      bit exp_par;
      bit pe;
      bit se;
      bit dv;
      nb      = pen ? 11 : 10;
      t_end   = s + nb * cur_p;
      t_par   = s + 10 * cur_p;
      exp_par = (($countones(d) % 2) == 1) ^ ptyp;
      pe      = pen && (pbit != exp_par);
      se      = !stp;
      dv      = stp && !pe;
      chk("par_err_count", 32'(pe_q.size()), 32'(pe));
      if (pe && pe_q.size() > 0) chk("par_err_cycle", 32'(pe_q.pop_front()), 32'(t_par));
      chk("stp_err_count", 32'(se_q.size()), 32'(se));
      if (se && se_q.size() > 0) chk("stp_err_cycle", 32'(se_q.pop_front()), 32'(t_end));
      chk("dv_count", 32'(dv_q.size()), 32'(dv));
      if (dv && dv_q.size() > 0) begin
         last_dv = dv_q.pop_front();
         chk("dv_cycle", 32'(last_dv), 32'(t_end));
         chk("dv_data", 32'(dvd_q.pop_front()), 32'(d));
      end
      if (dv) pdata_model = d;
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_no_extra"}, 32'(dv_q.size() + pe_q.size() + se_q.size() + sg_q.size()), 32'd0);
      chk({tag, "_p_data"}, 32'(P_DATA), 32'(pdata_model));
      dv_q.delete(); dvd_q.delete(); pe_q.delete(); se_q.delete(); sg_q.delete();
   endtask

   task automatic frame(input string tag, input logic [7:0] d, input bit pen, input bit ptyp,
                        input bit pbit, input bit stp, output int s);
      PAR_EN  = pen;
      PAR_TYP = ptyp;
      drive_frame(d, pen, pbit, stp, -1, s);
      end_frame();
      expect_frame(s, d, pen, ptyp, pbit, stp);
      check_quiet(tag);
   endtask

   initial begin
      int         s;
      int         s1;
      int         dv1;
      logic [7:0] rd;
      bit         rpen;
      bit         rtyp;
      bit         rpb;
      bit         rstp;
      bit         good;

      reset       = 1'b1;
      RX_IN       = 1'b1;
      sampled_bit = 1'b1;
      Prescale    = 5'd8;
      PAR_EN      = 1'b0;
      PAR_TYP     = 1'b0;
      cur_p       = 8;
      tick();
      tick();
      chk("rst_samp_en", 32'(data_samp_en), 32'd0);
      chk("rst_edge_cnt", 32'(edge_cnt), 32'd0);
      chk("rst_p_data", 32'(P_DATA), 32'd0);
      chk("rst_data_valid", 32'(data_valid), 32'd0);
      chk("rst_par_err", 32'(par_err), 32'd0);
      chk("rst_stp_err", 32'(stp_err), 32'd0);
      chk("rst_strt_glitch", 32'(strt_glitch), 32'd0);
      reset = 1'b0;
      repeat (3) tick();
      check_quiet("idle");

      frame("p8_even_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, s);
      tick();

      cur_p    = 16;
      Prescale = 5'd16;
      frame("p16_nopar_3c", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, s);
      tick();

      cur_p    = 8;
      Prescale = 5'd8;
      frame("p8_odd_bad", 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, s);
      tick();

      frame("p8_stop0", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, s);
      tick();

      // Start bit that votes high: one-cycle low pulse on the line.
      RX_IN = 1'b0;
      s     = cyc + 1;
      for (int j = 0; j < cur_p; j++) begin
         tick();
         RX_IN       = 1'b1;
         sampled_bit = 1'b1;
      end
      tick();
      chk("glitch_count", 32'(sg_q.size()), 32'd1);
      if (sg_q.size() > 0) chk("glitch_cycle", 32'(sg_q.pop_front()), 32'(s + cur_p));
      chk("glitch_samp_en", 32'(data_samp_en), 32'd0);
      check_quiet("glitch");
      tick();

      frame("b2b_first", 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, s1);
      dv1 = last_dv;
      frame("b2b_second", 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, s);
      chk("b2b_spacing", 32'(last_dv - dv1), 32'd81);
      tick();

      PAR_EN  = 1'b0;
      PAR_TYP = 1'b0;
      drive_frame(8'h77, 1'b0, 1'b0, 1'b1, 40, s);
      reset = 1'b1;
      #1;
      chk("mid_rst_samp_en", 32'(data_samp_en), 32'd0);
      chk("mid_rst_edge_cnt", 32'(edge_cnt), 32'd0);
      chk("mid_rst_p_data", 32'(P_DATA), 32'd0);
      chk("mid_rst_strobes", 32'({data_valid, par_err, stp_err, strt_glitch}), 32'd0);
      pdata_model = 8'h00;
      RX_IN       = 1'b1;
      sampled_bit = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      repeat (3) tick();
      check_quiet("after_rst");
      frame("post_rst_5a", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, s);

      for (int n = 0; n < 30; n++) begin
         int gap;
         gap      = $urandom_range(0, 3);
         repeat (gap) tick();
         cur_p    = 2 * $urandom_range(4, 15);
         Prescale = 5'(cur_p);
         rd       = 8'($urandom);
         rpen     = 1'($urandom);
         rtyp     = 1'($urandom);
         good     = (($countones(rd) % 2) == 1) ^ rtyp;
         rpb      = ($urandom_range(0, 3) == 0) ? !good : good;
         rstp     = ($urandom_range(0, 7) != 0);
         frame("rand", rd, rpen, rtyp, rpb, rstp, s);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Receive-side frame controller of the UART RX path. Detects the start edge on RX_IN, runs the edge and bit counters, enables the downstream 3-sample majority sampler, and consumes its voted sampled_bit. Deserializes the data bits LSB first, checks optional parity and the stop bit, and presents the byte to the register-file/sync stage with a one-cycle valid strobe.

## Interface
- DATA_WIDTH, 8, number of data bits per frame
- clk  in  1  RX oversampling clock (Prescale × baud)
- reset  in  1  asynchronous, active-high; clears all state
- RX_IN  in  1  serial line, already synchronized, idle high
- Prescale  in  5  oversampling ratio; supported 8 and 16 (any even value 8..30 legal); must be stable while a frame is in progress
- PAR_EN  in  1  1 = parity bit present after data
- PAR_TYP  in  1  0 = even, 1 = odd
- sampled_bit  in  1  voted bit from the sampler
- data_samp_en  out  1  sampler enable; high in every state except IDLE
- edge_cnt  out  5  oversampling edge index within current bit, 0..Prescale-1
- P_DATA  out  DATA_WIDTH  last good received word
- data_valid  out  1  one-cycle strobe, P_DATA updated
- par_err  out  1  one-cycle strobe, parity mismatch
- stp_err  out  1  one-cycle strobe, stop bit sampled 0
- strt_glitch  out  1  one-cycle strobe, start bit sampled 1

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Reset state IDLE.
- Sampler contract: sampled_bit for the current bit is valid from edge_cnt = Prescale/2+2 onward; FSM reads sampled_bit only at the last edge (edge_cnt = Prescale-1).
- edge_cnt: 0 in IDLE; in other states increments each cycle, wraps Prescale-1 → 0 (bit boundary). bit_cnt (internal, counts data bits) increments at each DATA bit boundary.
- IDLE: RX_IN = 0 → START next cycle with edge_cnt = 0; PAR_EN/PAR_TYP latched on this transition; changes mid-frame ignored.
- START, last edge: sampled_bit = 1 → strt_glitch pulse, IDLE. Else DATA, bit_cnt = 0.
- DATA, last edge: shift sampled_bit into internal shift register at MSB, shift right (first bit lands at bit 0 after DATA_WIDTH shifts). After DATA_WIDTH-th bit → PARITY if latched PAR_EN, else STOP.
- PARITY, last edge: expected = XOR of shift register (even), inverted for odd. Mismatch → par_err pulse next cycle, internal error flag set. → STOP.
- STOP, last edge: sampled_bit = 0 → stp_err pulse next cycle. If stop = 1 and no parity error → P_DATA loaded from shift register, data_valid pulse next cycle. Always → IDLE.
- Frame with error: P_DATA holds previous value; data_valid stays 0.
- Back-to-back frames: IDLE entered after stop; RX_IN = 0 in that IDLE cycle starts next frame immediately.
- Reset mid-frame: all outputs, counters, shift register and flags to 0, state IDLE, effective next clock after deassertion.

## Timing
- Reset values: data_samp_en 0, edge_cnt 0, P_DATA 0, data_valid 0, par_err 0, stp_err 0, strt_glitch 0.
- All outputs registered.
- Let S = first START cycle (edge_cnt = 0); IDLE detect cycle = S-1.
- Bit k (start = 0) last edge at S + k·Prescale + Prescale-1.
- Frame bits N = 1 + DATA_WIDTH + PAR_EN + 1; data_valid / stp_err high in cycle S + N·Prescale, exactly one cycle; par_err in cycle S + (DATA_WIDTH+2)·Prescale.
- strt_glitch high in cycle S + Prescale.
- data_samp_en rises in cycle S, falls in the cycle the strobes are high.
- Flags never overlap data_valid within one frame.

## Test plan
- Prescale 8, PAR_EN 1 even, frame 0xA5 parity 0 stop 1 -> data_valid at S+88, P_DATA = 0xA5, no errors.
- Prescale 16, PAR_EN 0, frame 0x3C -> data_valid at S+160, P_DATA = 0x3C; edge_cnt wraps 15→0 at each boundary.
- Prescale 8, PAR_EN 1 odd, frame 0xA5 with parity 0 -> par_err at S+80, no data_valid, P_DATA keeps 0x3C from prior frame.
- Prescale 8, PAR_EN 0, frame 0x01 stop = 0 -> stp_err at S+80, no data_valid; RX_IN 1-cycle low pulse -> strt_glitch at S+8, return to IDLE.
- Two back-to-back frames 0x11, 0x22 (Prescale 8, no parity) -> two data_valid pulses 80 cycles apart-plus-one, P_DATA 0x11 then 0x22.
- reset asserted at S+40 mid-DATA -> all outputs 0 immediately; clean frame 0x5A afterwards -> data_valid, P_DATA = 0x5A.
